player_card_in_pio: RTL and testbench
=====================================

PLAYER_CARD_IN_PIO -- requirements
Module: player_card_in_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits captured, 1..32.
REQ-002 Parameter EDGE_MODE, default 0: edge detection type (0 = rising, 1 = falling, 2 = any).
REQ-003 Port clk, input, 1: single clock for all logic; this block SHALL have one clock.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port address, input, 2: Avalon-MM slave register select.
REQ-006 Port chipselect, input, 1: Avalon-MM slave select.
REQ-007 Port write_n, input, 1: Avalon-MM write strobe, active-low.
REQ-008 Port writedata, input, 32: Avalon-MM write data.
REQ-009 Port in_port, input, WIDTH: asynchronous fabric-side inputs (player card/button lines).
REQ-010 Port readdata, output, 32: Avalon-MM read data.
REQ-011 Port irq, output, 1: level interrupt to the HPS, active-high.

Function
REQ-012 in_port SHALL pass through a two-flop synchronizer (s1, s2); a third register s3 SHALL hold the previous s2 for edge detection.
REQ-013 Register map: addr 0 = data (s2, RO); addr 1 = reserved (reads 0, writes ignored); addr 2 = irqmask (RW, WIDTH bits); addr 3 = edgecapture (RW1C, WIDTH bits).
REQ-014 readdata SHALL be combinational from address, zero-extended to 32 bits, with zero wait states; reads SHALL have no side effects.
REQ-015 A write SHALL occur on a rising clk when chipselect=1 and write_n=0; otherwise register state SHALL be unchanged except for edge capture.
REQ-016 A write to addr 2 SHALL load irqmask with writedata[WIDTH-1:0] on that clock edge.
REQ-017 A write to addr 3 SHALL clear each edgecapture bit whose writedata bit is 1 and leave bits whose writedata bit is 0 unchanged.
REQ-018 Edge detect per bit: rising = s2 & ~s3; falling = ~s2 & s3; any = s2 ^ s3; the detected bit SHALL set its edgecapture bit on the next clock edge.
REQ-019 Latency: an in_port change sampled at edge k SHALL appear in data at edge k+1, set edgecapture at edge k+2, and assert irq after edge k+2.
REQ-020 If a set and a clear of the same edgecapture bit occur in the same cycle, set SHALL win and the bit SHALL remain 1.
REQ-021 Edgecapture bits SHALL be sticky: further edges on a set bit SHALL have no additional effect and SHALL NOT be counted.
REQ-022 irq SHALL equal OR-reduce(edgecapture & irqmask) and SHALL be combinational from registered state, with no glitch-generating inputs.
REQ-023 Changing irqmask SHALL affect irq in the cycle after the write, without altering edgecapture.
REQ-024 Pulses on in_port shorter than one clk period are not guaranteed capture; pulses of at least 2 clk periods SHALL be captured.
REQ-025 Bits at or above WIDTH SHALL read 0 at every address and SHALL ignore writes.

Reset
REQ-026 When reset_n=0, s1, s2, s3, irqmask and edgecapture SHALL clear to 0 immediately, independent of clk; readdata at addr 0/2/3 SHALL then read 0 and irq SHALL be 0.
REQ-027 An in_port bit held high through reset release SHALL be treated as a rising edge two cycles after release, and captured when EDGE_MODE is 0 or 2.
REQ-028 Reset asserted mid-operation SHALL discard pending edges and the mask; an Avalon write concurrent with reset SHALL be ignored.

Verification
REQ-029 Reset, then set in_port=0xA5 and hold 3 clocks, then read addr 0 -> readdata=0x000000A5.
REQ-030 EDGE_MODE=0, irqmask=0x01, in_port bit0 0->1 at edge k -> edgecapture=0x01 at k+2 and irq=1; write 0x01 to addr 3 -> irq=0 the next cycle.
REQ-031 A rising edge on bit3 detected in the same cycle as a write of 0x08 to addr 3 -> edgecapture bit3 stays 1.
REQ-032 edgecapture=0x10 with irqmask=0 -> irq=0; write irqmask=0x10 -> irq=1 the next cycle; read addr 2 -> 0x10.
REQ-033 EDGE_MODE=2, toggle bit7 twice spaced 4 clocks apart -> edgecapture bit7=1 after the first toggle and stays 1; write 0xFF to addr 1, then read addr 1 -> 0.
REQ-034 Assert reset_n=0 asynchronously while irq=1 -> irq, irqmask and edgecapture read 0 with no clk edge required.

Source files
------------

// File: rtl/player_card_in_pio.sv
// player_card_in_pio
//   Avalon-MM parallel input port for player card / button lines with
//   per-bit edge capture and a maskable level interrupt.
//
//   Parameters
//     WIDTH      number of input bits captured (1..32)
//     EDGE_MODE  0 = rising, 1 = falling, 2 = any edge
//
//   Ports
//     clk         single clock for all logic
//     reset_n     asynchronous active-low reset
//     address     register select: 0 data (RO), 1 reserved,
//                 2 irqmask (RW), 3 edgecapture (RW1C)
//     chipselect  slave select
//     write_n     active-low write strobe
//     writedata   write data
//     in_port     asynchronous fabric-side inputs
//     readdata    combinational read data, zero-extended
//     irq         active-high level interrupt
module player_card_in_pio #(
   parameter int WIDTH     = 8,
   parameter int EDGE_MODE = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] s3;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clear_mask;
   logic             wr;

   assign wr = chipselect & ~write_n;

   always_comb begin
      edge_det = '0;
      case (EDGE_MODE)
         0:       edge_det = s2 & ~s3;
         1:       edge_det = ~s2 & s3;
         default: edge_det = s2 ^ s3;
      endcase
   end

   always_comb begin
      clear_mask = '0;
      if (wr && (address == 2'd3))
         clear_mask = writedata[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1          <= '0;
         s2          <= '0;
         s3          <= '0;
         irqmask     <= '0;
         edgecapture <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
         s3 <= s2;
         if (wr && (address == 2'd2))
            irqmask <= writedata[WIDTH-1:0];
         // set is OR-ed in after the clear so a same-cycle edge wins
         edgecapture <= (edgecapture & ~clear_mask) | edge_det;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = s2;
         2'd2:    readdata[WIDTH-1:0] = irqmask;
         2'd3:    readdata[WIDTH-1:0] = edgecapture;
         default: readdata = '0;
      endcase
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_player_card_in_pio.sv
// Directed bench for player_card_in_pio: one instance in rising-edge mode
// (dut0) and one in any-edge mode (dut2) share the Avalon bus.
module tb_player_card_in_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port0;
   logic [7:0]  in_port2;
   logic [31:0] rd0;
   logic [31:0] rd2;
   logic        irq0;
   logic        irq2;

   int total = 0;
   int bad   = 0;

   logic [31:0] r0;
   logic [31:0] r2;

   always #5 clk = ~clk;

   player_card_in_pio #(.WIDTH(8), .EDGE_MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port0),
      .readdata(rd0), .irq(irq0)
   );

   player_card_in_pio #(.WIDTH(8), .EDGE_MODE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port2),
      .readdata(rd2), .irq(irq2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v0, output logic [31:0] v2);
      address = a;
      #1;
      v0 = rd0;
      v2 = rd2;
   endtask

   // called at a negedge; the write happens on the next posedge
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port0   = 8'h00;
      in_port2   = 8'h01;
      cyc(3);

      // reset state
      rd(2'd0, r0, r2); check("rst_data", r0, 32'h0);
      rd(2'd2, r0, r2); check("rst_mask", r0, 32'h0);
      rd(2'd3, r0, r2); check("rst_ec", r0, 32'h0);
      check("rst_irq", {31'b0, irq0}, 32'h0);

      // dut2 bit0 held high through release: captured on third edge
      @(negedge clk);
      reset_n = 1'b1;
      cyc(2);
      rd(2'd3, r0, r2); check("rel_ec_early", r2, 32'h0);
      cyc(1);
      rd(2'd3, r0, r2); check("rel_ec_capt", r2, 32'h01);
      bus_write(2'd3, 32'hFF);
      rd(2'd3, r0, r2); check("rel_ec_clr", r2, 32'h0);

      // data path latency and rising capture of 0xA5
      in_port0 = 8'hA5;
      cyc(1);
      rd(2'd0, r0, r2); check("data_lat1", r0, 32'h0);
      cyc(1);
      rd(2'd0, r0, r2); check("data_lat2", r0, 32'hA5);
      cyc(1);
      rd(2'd0, r0, r2); check("data_hold", r0, 32'h000000A5);
      rd(2'd3, r0, r2); check("ec_a5", r0, 32'hA5);
      check("irq_nomask", {31'b0, irq0}, 32'h0);
      bus_write(2'd3, 32'hFF);
      rd(2'd3, r0, r2); check("ec_clr_all", r0, 32'h0);

      // falling edge ignored in rising mode, then rising edge on bit0
      bus_write(2'd2, 32'h01);
      in_port0 = 8'hA4;
      cyc(3);
      rd(2'd3, r0, r2); check("ec_fall_ign", r0, 32'h0);
      in_port0 = 8'hA5;
      cyc(2);
      rd(2'd3, r0, r2); check("ec_k1", r0, 32'h0);
      check("irq_k1", {31'b0, irq0}, 32'h0);
      cyc(1);
      rd(2'd3, r0, r2); check("ec_k2", r0, 32'h01);
      check("irq_k2", {31'b0, irq0}, 32'h1);
      bus_write(2'd3, 32'h01);
      check("irq_cleared", {31'b0, irq0}, 32'h0);
      rd(2'd3, r0, r2); check("ec_b0_clr", r0, 32'h0);

      // set beats clear on bit3
      in_port0 = 8'hAD;
      cyc(2);
      bus_write(2'd3, 32'h08);
      rd(2'd3, r0, r2); check("set_wins", r0, 32'h08);
      bus_write(2'd3, 32'h08);
      rd(2'd3, r0, r2); check("b3_clr", r0, 32'h0);

      // mask change drives irq without touching edgecapture
      bus_write(2'd2, 32'h00);
      in_port0 = 8'hBD;
      cyc(3);
      rd(2'd3, r0, r2); check("ec_b4", r0, 32'h10);
      check("irq_mask0", {31'b0, irq0}, 32'h0);
      bus_write(2'd2, 32'h10);
      check("irq_mask10", {31'b0, irq0}, 32'h1);
      rd(2'd2, r0, r2); check("mask_rd", r0, 32'h10);
      rd(2'd3, r0, r2); check("ec_kept", r0, 32'h10);

      // asynchronous reset mid-cycle, no clock edge in between
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_irq", {31'b0, irq0}, 32'h0);
      rd(2'd2, r0, r2); check("arst_mask", r0, 32'h0);
      rd(2'd3, r0, r2); check("arst_ec", r0, 32'h0);
      rd(2'd0, r0, r2); check("arst_data", r0, 32'h0);
      in_port2 = 8'h00;
      @(negedge clk);
      bus_write(2'd2, 32'hFF);
      @(negedge clk);
      reset_n = 1'b1;
      rd(2'd2, r0, r2); check("wr_in_rst", r0, 32'h0);
      cyc(2);
      rd(2'd3, r0, r2); check("rel0_early", r0, 32'h0);
      cyc(1);
      rd(2'd3, r0, r2); check("rel0_capt", r0, 32'hBD);

      // any-edge mode on bit7: sticky through second toggle
      in_port2 = 8'h80;
      cyc(3);
      rd(2'd3, r0, r2); check("any_rise", r2, 32'h80);
      cyc(1);
      in_port2 = 8'h00;
      cyc(3);
      rd(2'd3, r0, r2); check("any_sticky", r2, 32'h80);
      bus_write(2'd3, 32'h80);
      rd(2'd3, r0, r2); check("any_clr", r2, 32'h0);
      in_port2 = 8'h80;
      cyc(3);
      bus_write(2'd3, 32'h80);
      in_port2 = 8'h00;
      cyc(3);
      rd(2'd3, r0, r2); check("any_fall", r2, 32'h80);
      check("any_irq_nomask", {31'b0, irq2}, 32'h0);

      // reserved address and upper bits
      bus_write(2'd2, 32'hFFFFFFFF);
      rd(2'd2, r0, r2); check("mask_width", r2, 32'hFF);
      check("any_irq_mask", {31'b0, irq2}, 32'h1);
      bus_write(2'd1, 32'hFF);
      rd(2'd1, r0, r2); check("resv_rd0", r0, 32'h0);
      check("resv_rd2", r2, 32'h0);
      rd(2'd2, r0, r2); check("resv_nowr", r2, 32'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
